// File: rtl/uart_frame_tx_if.sv
// Sample-in / byte-out handshake bundle for the packet framer.
interface uart_frame_tx_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        pkt_active;
  logic        overflow;

  // Framer side
  modport slave (
    input  in_valid, in_data, flush, tx_busy,
    output in_ready, tx_start, tx_data, pkt_active, overflow
  );

  // Sample source / transmitter side
  modport master (
    output in_valid, in_data, flush, tx_busy,
    input  in_ready, tx_start, tx_data, pkt_active, overflow
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Packet framer: buffers 16-bit samples and emits SYNC0 SYNC1 LEN {lo hi}* CHK
// byte by byte over a start/busy transmitter handshake.
module uart_frame_tx #(
  parameter int         DEPTH   = 16,
  parameter int         PKT_LEN = 8,
  parameter logic [7:0] SYNC0   = 8'hAA,
  parameter logic [7:0] SYNC1   = 8'h55
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_frame_tx_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    P_IDLE, P_HDR0, P_HDR1, P_LENB, P_DLO, P_DHI, P_CHKB
  } pstate_e;

  typedef enum logic [1:0] {
    B_LOAD, B_START, B_ACK, B_DONE
  } bstate_e;

  pstate_e pstate_q, pstate_d;
  bstate_e bstate_q, bstate_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, in_ready;

  logic [7:0] len_q, len_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] byte_sel;
  logic       flush_pend_q, flush_pend_d;
  logic       overflow_q;

  // in_ready comes from the registered count only, so a pop frees a slot next cycle
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign pop      = (pstate_q == P_DHI) && (bstate_q == B_START);

  assign bus.in_ready   = in_ready;
  assign bus.tx_start   = (bstate_q == B_START);
  assign bus.tx_data    = tx_data_q;
  assign bus.pkt_active = (pstate_q != P_IDLE);
  assign bus.overflow   = overflow_q;

  // Sample storage (contents need no reset; count/pointers define validity)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.in_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Byte to present for the current packet state
  always_comb begin
    byte_sel = SYNC0;
    case (pstate_q)
      P_HDR0:  byte_sel = SYNC0;
      P_HDR1:  byte_sel = SYNC1;
      P_LENB:  byte_sel = len_q;
      P_DLO:   byte_sel = mem[rd_ptr_q][7:0];
      P_DHI:   byte_sel = mem[rd_ptr_q][15:8];
      P_CHKB:  byte_sel = 8'h00 - sum_q;
      default: byte_sel = SYNC0;
    endcase
  end

  // Packet and byte FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q     <= P_IDLE;
      bstate_q     <= B_LOAD;
      len_q        <= '0;
      rem_q        <= '0;
      sum_q        <= '0;
      tx_data_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      pstate_q     <= pstate_d;
      bstate_q     <= bstate_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      sum_q        <= sum_d;
      tx_data_q    <= tx_data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Launch decision, per-byte handshake and packet sequencing
  always_comb begin
    pstate_d     = pstate_q;
    bstate_d     = bstate_q;
    len_d        = len_q;
    rem_d        = rem_q;
    sum_d        = sum_q;
    tx_data_d    = tx_data_q;
    flush_pend_d = flush_pend_q;

    if (pstate_q == P_IDLE) begin
      bstate_d = B_LOAD;
      if (count_q >= CW'(PKT_LEN)) begin
        pstate_d = P_HDR0;
        len_d    = 8'(PKT_LEN);
        rem_d    = 8'(PKT_LEN);
        sum_d    = 8'(PKT_LEN);
      end else if (flush_pend_q) begin
        flush_pend_d = 1'b0;
        if (count_q != '0) begin
          pstate_d = P_HDR0;
          len_d    = 8'(count_q);
          rem_d    = 8'(count_q);
          sum_d    = 8'(count_q);
        end
      end
    end else begin
      case (bstate_q)
        B_LOAD: begin
          tx_data_d = byte_sel;
          if (!bus.tx_busy) bstate_d = B_START;
        end
        B_START: begin
          bstate_d = B_ACK;
          if (pstate_q == P_DLO || pstate_q == P_DHI) sum_d = sum_q + tx_data_q;
        end
        B_ACK: begin
          if (bus.tx_busy) bstate_d = B_DONE;
        end
        B_DONE: begin
          if (!bus.tx_busy) begin
            bstate_d = B_LOAD;
            case (pstate_q)
              P_HDR0: pstate_d = P_HDR1;
              P_HDR1: pstate_d = P_LENB;
              P_LENB: pstate_d = P_DLO;
              P_DLO:  pstate_d = P_DHI;
              P_DHI: begin
                rem_d    = rem_q - 1'b1;
                pstate_d = (rem_q == 8'd1) ? P_CHKB : P_DLO;
              end
              P_CHKB:  pstate_d = P_IDLE;
              default: pstate_d = P_IDLE;
            endcase
          end
        end
        default: bstate_d = B_LOAD;
      endcase
    end

    if (bus.flush) flush_pend_d = 1'b1;
  end

endmodule
